decode_stage_hz: RTL and testbench

Parametrised MIPS-subset instruction-decode stage for the 5-stage pipeline. It contains:
- the register file,
- the control decoder, including a new addi mode,
- the immediate sign-extender,
- the ID/EX pipeline register.

---
 rtl/decode_stage_hz.sv | 229 ++++++++++++++++++++++
 tb/tb_decode_stage_hz.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hz.sv
// Purpose: MIPS-subset ID stage (regfile, control decode, sign-extend, ID/EX register) with load-use stall.
// Latency: one cycle from IF/ID to ID/EX; regfile reads are combinational with optional WB bypass.
// Backpressure: stall asks fetch to hold PC and IF/ID while a bubble is pushed into EX; flush overrides it.
module decode_stage_hz #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int PC_W       = 32,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS_EN  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_write_reg_location,
   input  logic [DATA_W-1:0]     mem_wb_write_data,
   input  logic [31:0]           if_id_instr,
   input  logic [PC_W-1:0]       if_id_npc,
   input  logic                  if_id_valid,
   input  logic                  flush,
   output logic                  stall,
   output logic                  id_ex_valid,
   output logic [1:0]            id_ex_wb,
   output logic [2:0]            id_ex_mem,
   output logic [3:0]            id_ex_execute,
   output logic [PC_W-1:0]       id_ex_npc,
   output logic [DATA_W-1:0]     id_ex_read_data_1,
   output logic [DATA_W-1:0]     id_ex_read_data_2,
   output logic [DATA_W-1:0]     id_ex_sign_ext,
   output logic [REG_ADDR_W-1:0] id_ex_instr_bits_25_21,
   output logic [REG_ADDR_W-1:0] id_ex_instr_bits_20_16,
   output logic [REG_ADDR_W-1:0] id_ex_instr_bits_15_11
);

   localparam int NREGS = 2 ** REG_ADDR_W;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   // Control bundle as it travels to EX/MEM/WB.
   typedef struct packed {
      logic [1:0] wb;   // {regwrite, memtoreg}
      logic [2:0] mem;  // {branch, memread, memwrite}
      logic [3:0] ex;   // {regdst, aluop[1:0], alusrc}
   } ctrl_t;

   // ------------------------------------------------------------------
   // Instruction field extraction
   // ------------------------------------------------------------------
   logic [5:0]            w_opcode;
   logic [REG_ADDR_W-1:0] w_rs_idx;
   logic [REG_ADDR_W-1:0] w_rt_idx;
   logic [REG_ADDR_W-1:0] w_rd_idx;
   logic [DATA_W-1:0]     w_sign_ext;

   assign w_opcode   = if_id_instr[31:26];
   assign w_rs_idx   = REG_ADDR_W'(if_id_instr[25:21]);
   assign w_rt_idx   = REG_ADDR_W'(if_id_instr[20:16]);
   assign w_rd_idx   = REG_ADDR_W'(if_id_instr[15:11]);
   // Signed cast replicates instr[15] into every bit above 15.
   assign w_sign_ext = DATA_W'($signed(if_id_instr[15:0]));

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] r_rf [NREGS];
   logic              w_rf_we;

   // Register 0 is hard-wired when ZERO_REG is set, so its writes are dropped.
   assign w_rf_we = wb_reg_write &&
                    (!ZERO_REG || (wb_write_reg_location != '0));

   // Writeback port; reset clears every entry so stale state never survives a reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_rf[i] <= '0;
         end
      end else if (w_rf_we) begin
         r_rf[wb_write_reg_location] <= mem_wb_write_data;
      end
   end

   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_fwd_rs;
   logic              w_fwd_rt;

   // Writeback forwarding: the value being written this cycle is visible to ID now.
   assign w_fwd_rs = BYPASS_EN && wb_reg_write &&
                     (wb_write_reg_location == w_rs_idx) &&
                     (!ZERO_REG || (w_rs_idx != '0));
   assign w_fwd_rt = BYPASS_EN && wb_reg_write &&
                     (wb_write_reg_location == w_rt_idx) &&
                     (!ZERO_REG || (w_rt_idx != '0));

   // Combinational read ports with bypass and hard-wired zero register.
   always_comb begin
      w_rd1 = r_rf[w_rs_idx];
      w_rd2 = r_rf[w_rt_idx];
      if (w_fwd_rs) begin
         w_rd1 = mem_wb_write_data;
      end
      if (w_fwd_rt) begin
         w_rd2 = mem_wb_write_data;
      end
      if (ZERO_REG && (w_rs_idx == '0)) begin
         w_rd1 = '0;
      end
      if (ZERO_REG && (w_rt_idx == '0)) begin
         w_rd2 = '0;
      end
   end

   // ------------------------------------------------------------------
   // Control decode
   // ------------------------------------------------------------------
   ctrl_t w_ctrl;
   logic  w_uses_rt;

   // Opcode to control bundle; unknown opcodes decode as a NOP but stay valid.
   always_comb begin
      w_ctrl    = '0;
      w_uses_rt = 1'b0;
      case (w_opcode)
         OP_RTYPE: begin
            w_ctrl.ex  = 4'b1100;
            w_ctrl.mem = 3'b000;
            w_ctrl.wb  = 2'b10;
            w_uses_rt  = 1'b1;
         end
         OP_LW: begin
            w_ctrl.ex  = 4'b0001;
            w_ctrl.mem = 3'b010;
            w_ctrl.wb  = 2'b11;
         end
         OP_SW: begin
            w_ctrl.ex  = 4'b0001;
            w_ctrl.mem = 3'b001;
            w_ctrl.wb  = 2'b00;
            w_uses_rt  = 1'b1;
         end
         OP_BEQ: begin
            w_ctrl.ex  = 4'b0010;
            w_ctrl.mem = 3'b100;
            w_ctrl.wb  = 2'b00;
            w_uses_rt  = 1'b1;
         end
         OP_ADDI: begin
            w_ctrl.ex  = 4'b0001;
            w_ctrl.mem = 3'b000;
            w_ctrl.wb  = 2'b10;
         end
         default: begin
            w_ctrl    = '0;
            w_uses_rt = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Load-use hazard detection
   // ------------------------------------------------------------------
   logic                  r_valid;
   ctrl_t                 r_ctrl;
   logic [PC_W-1:0]       r_npc;
   logic [DATA_W-1:0]     r_rd1;
   logic [DATA_W-1:0]     r_rd2;
   logic [DATA_W-1:0]     r_sign_ext;
   logic [REG_ADDR_W-1:0] r_rs_idx;
   logic [REG_ADDR_W-1:0] r_rt_idx;
   logic [REG_ADDR_W-1:0] r_rd_idx;

   logic w_hz;
   logic w_bubble;

   // A load in EX whose destination feeds the ID instruction; register 0 is not exempt
   // because a load to $0 is rare enough that the extra bubble is harmless.
   assign w_hz = r_valid && r_ctrl.mem[1] && if_id_valid &&
                 ((r_rt_idx == w_rs_idx) ||
                  (w_uses_rt && (r_rt_idx == w_rt_idx)));

   // Flush wins over stall: the squashed instruction must not hold fetch.
   assign stall    = w_hz && !flush;
   assign w_bubble = flush || w_hz || !if_id_valid;

   // ------------------------------------------------------------------
   // ID/EX pipeline register
   // ------------------------------------------------------------------
   // Loads every edge; a bubble only clears valid and controls, data fields are don't-care in EX.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid    <= 1'b0;
         r_ctrl     <= '0;
         r_npc      <= '0;
         r_rd1      <= '0;
         r_rd2      <= '0;
         r_sign_ext <= '0;
         r_rs_idx   <= '0;
         r_rt_idx   <= '0;
         r_rd_idx   <= '0;
      end else begin
         r_valid    <= !w_bubble;
         r_ctrl     <= w_bubble ? ctrl_t'('0) : w_ctrl;
         r_npc      <= if_id_npc;
         r_rd1      <= w_rd1;
         r_rd2      <= w_rd2;
         r_sign_ext <= w_sign_ext;
         r_rs_idx   <= w_rs_idx;
         r_rt_idx   <= w_rt_idx;
         r_rd_idx   <= w_rd_idx;
      end
   end

   assign id_ex_valid            = r_valid;
   assign id_ex_wb               = r_ctrl.wb;
   assign id_ex_mem              = r_ctrl.mem;
   assign id_ex_execute          = r_ctrl.ex;
   assign id_ex_npc              = r_npc;
   assign id_ex_read_data_1      = r_rd1;
   assign id_ex_read_data_2      = r_rd2;
   assign id_ex_sign_ext         = r_sign_ext;
   assign id_ex_instr_bits_25_21 = r_rs_idx;
   assign id_ex_instr_bits_20_16 = r_rt_idx;
   assign id_ex_instr_bits_15_11 = r_rd_idx;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Purpose: directed-vector bench for decode_stage_hz, with and without writeback bypass.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next edge.
// Backpressure: the bench plays fetch, holding IF/ID while stall is high.
module tb_decode_stage_hz;

   logic        clk;
   logic        rst;
   logic        wb_reg_write;
   logic [4:0]  wb_loc;
   logic [31:0] wb_data;
   logic [31:0] instr;
   logic [31:0] npc;
   logic        valid;
   logic        flush;

   // DUT A: bypass enabled
   logic        a_stall, a_valid;
   logic [1:0]  a_wb;
   logic [2:0]  a_mem;
   logic [3:0]  a_ex;
   logic [31:0] a_npc, a_rd1, a_rd2, a_sext;
   logic [4:0]  a_rs, a_rt, a_rd;

   // DUT B: bypass disabled
   logic        b_stall, b_valid;
   logic [1:0]  b_wb;
   logic [2:0]  b_mem;
   logic [3:0]  b_ex;
   logic [31:0] b_npc, b_rd1, b_rd2, b_sext;
   logic [4:0]  b_rs, b_rt, b_rd;

   int n_vec = 0;
   int n_err = 0;

   decode_stage_hz #(.BYPASS_EN(1'b1)) u_dut_a (
      .clk(clk), .rst(rst),
      .wb_reg_write(wb_reg_write), .wb_write_reg_location(wb_loc), .mem_wb_write_data(wb_data),
      .if_id_instr(instr), .if_id_npc(npc), .if_id_valid(valid), .flush(flush),
      .stall(a_stall), .id_ex_valid(a_valid), .id_ex_wb(a_wb), .id_ex_mem(a_mem),
      .id_ex_execute(a_ex), .id_ex_npc(a_npc), .id_ex_read_data_1(a_rd1),
      .id_ex_read_data_2(a_rd2), .id_ex_sign_ext(a_sext),
      .id_ex_instr_bits_25_21(a_rs), .id_ex_instr_bits_20_16(a_rt), .id_ex_instr_bits_15_11(a_rd)
   );

   decode_stage_hz #(.BYPASS_EN(1'b0)) u_dut_b (
      .clk(clk), .rst(rst),
      .wb_reg_write(wb_reg_write), .wb_write_reg_location(wb_loc), .mem_wb_write_data(wb_data),
      .if_id_instr(instr), .if_id_npc(npc), .if_id_valid(valid), .flush(flush),
      .stall(b_stall), .id_ex_valid(b_valid), .id_ex_wb(b_wb), .id_ex_mem(b_mem),
      .id_ex_execute(b_ex), .id_ex_npc(b_npc), .id_ex_read_data_1(b_rd1),
      .id_ex_read_data_2(b_rd2), .id_ex_sign_ext(b_sext),
      .id_ex_instr_bits_25_21(b_rs), .id_ex_instr_bits_20_16(b_rt), .id_ex_instr_bits_15_11(b_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; wb_reg_write = 1'b0; wb_loc = '0; wb_data = '0;
      instr = '0; npc = '0; valid = 1'b0; flush = 1'b0;
      repeat (2) tick();
      n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0h want 0", a_valid); end
      n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %0h want 0", a_stall); end
      n_vec++; if ({a_wb, a_mem, a_ex} !== 9'h0) begin n_err++; $display("FAIL reset_ctrl got %0h want 0", {a_wb, a_mem, a_ex}); end
      n_vec++; if ({a_npc, a_rd1, a_rd2, a_sext} !== 128'h0) begin n_err++; $display("FAIL reset_data got %0h want 0", {a_npc, a_rd1, a_rd2, a_sext}); end
      n_vec++; if ({a_rs, a_rt, a_rd} !== 15'h0) begin n_err++; $display("FAIL reset_idx got %0h want 0", {a_rs, a_rt, a_rd}); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_rtype();
      wb_reg_write = 1'b1; wb_loc = 5'd4; wb_data = 32'h10;
      tick();
      wb_loc = 5'd5; wb_data = 32'h20;
      tick();
      wb_reg_write = 1'b0;
      instr = 32'h00a41020; npc = 32'd1; valid = 1'b1;
      tick();
      n_vec++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL rtype_valid got %0h want 1", a_valid); end
      n_vec++; if (a_ex !== 4'b1100) begin n_err++; $display("FAIL rtype_ex got %b want 1100", a_ex); end
      n_vec++; if (a_wb !== 2'b10) begin n_err++; $display("FAIL rtype_wb got %b want 10", a_wb); end
      n_vec++; if (a_mem !== 3'b000) begin n_err++; $display("FAIL rtype_mem got %b want 000", a_mem); end
      n_vec++; if (a_rd1 !== 32'h20) begin n_err++; $display("FAIL rtype_rd1 got %0h want 20", a_rd1); end
      n_vec++; if (a_rd2 !== 32'h10) begin n_err++; $display("FAIL rtype_rd2 got %0h want 10", a_rd2); end
      n_vec++; if ({a_rs, a_rt, a_rd} !== {5'd5, 5'd4, 5'd2}) begin n_err++; $display("FAIL rtype_idx got %0h want %0h", {a_rs, a_rt, a_rd}, {5'd5, 5'd4, 5'd2}); end
      n_vec++; if (a_npc !== 32'd1) begin n_err++; $display("FAIL rtype_npc got %0h want 1", a_npc); end
      n_vec++; if (b_rd1 !== 32'h20) begin n_err++; $display("FAIL rtype_b_rd1 got %0h want 20", b_rd1); end
   endtask

   task automatic test_bypass();
      wb_reg_write = 1'b1; wb_loc = 5'd2; wb_data = 32'h64;
      instr = 32'h00421020; npc = 32'd2; valid = 1'b1;
      tick();
      wb_reg_write = 1'b0;
      n_vec++; if (a_rd1 !== 32'h64) begin n_err++; $display("FAIL bypass_rd1 got %0h want 64", a_rd1); end
      n_vec++; if (a_rd2 !== 32'h64) begin n_err++; $display("FAIL bypass_rd2 got %0h want 64", a_rd2); end
      n_vec++; if (b_rd1 !== 32'h0) begin n_err++; $display("FAIL nobypass_rd1 got %0h want 0", b_rd1); end
      n_vec++; if (b_rd2 !== 32'h0) begin n_err++; $display("FAIL nobypass_rd2 got %0h want 0", b_rd2); end
      tick();
      n_vec++; if (b_rd1 !== 32'h64) begin n_err++; $display("FAIL nobypass_late got %0h want 64", b_rd1); end
   endtask

   task automatic test_load_use();
      instr = 32'h8c820002; npc = 32'd3; valid = 1'b1;
      tick();
      n_vec++; if (a_mem !== 3'b010) begin n_err++; $display("FAIL lw_mem got %b want 010", a_mem); end
      n_vec++; if ({a_wb, a_ex} !== 6'b11_0001) begin n_err++; $display("FAIL lw_wb_ex got %b want 110001", {a_wb, a_ex}); end
      n_vec++; if (a_sext !== 32'h00000002) begin n_err++; $display("FAIL lw_sext got %0h want 2", a_sext); end
      instr = 32'h00421020; npc = 32'd4;
      #1;
      n_vec++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %0h want 1", a_stall); end
      tick();
      n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble_valid got %0h want 0", a_valid); end
      n_vec++; if ({a_wb, a_mem, a_ex} !== 9'h0) begin n_err++; $display("FAIL lu_bubble_ctrl got %0h want 0", {a_wb, a_mem, a_ex}); end
      n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_drop got %0h want 0", a_stall); end
      tick();
      n_vec++; if ({a_valid, a_ex, a_wb} !== 7'b1_1100_10) begin n_err++; $display("FAIL lu_add got %b want 1110010", {a_valid, a_ex, a_wb}); end
      n_vec++; if (a_rd1 !== 32'h64) begin n_err++; $display("FAIL lu_add_rd1 got %0h want 64", a_rd1); end
      n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL lu_add_stall got %0h want 0", a_stall); end
   endtask

   task automatic test_flush_hazard();
      instr = 32'h8c820002; npc = 32'd5; valid = 1'b1;
      tick();
      instr = 32'h00421020; npc = 32'd6; flush = 1'b1;
      #1;
      n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got %0h want 0", a_stall); end
      tick();
      flush = 1'b0;
      n_vec++; if ({a_valid, a_wb, a_mem, a_ex} !== 10'h0) begin n_err++; $display("FAIL flush_bubble got %0h want 0", {a_valid, a_wb, a_mem, a_ex}); end
   endtask

   task automatic test_hazard_edges();
      instr = 32'h8c820002; valid = 1'b1;
      tick();
      instr = 32'h20620005;   // addi rs=3, rt=2: rt not a source
      #1;
      n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL hz_addi_rt got %0h want 0", a_stall); end
      instr = 32'h00421020; valid = 1'b0;
      #1;
      n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL hz_invalid got %0h want 0", a_stall); end
      valid = 1'b1;
      #1;
      n_vec++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL hz_rs_rt got %0h want 1", a_stall); end
      tick();
      instr = 32'h8c800000;   // lw to $0
      tick();
      instr = 32'h00001020;   // reads $0
      #1;
      n_vec++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL hz_reg0 got %0h want 1", a_stall); end
      tick();
   endtask

   task automatic test_decode();
      instr = 32'hac82fffe; valid = 1'b1;
      tick();
      n_vec++; if (a_sext !== 32'hfffffffe) begin n_err++; $display("FAIL sw_sext got %0h want fffffffe", a_sext); end
      n_vec++; if ({a_wb, a_mem, a_ex} !== 9'b00_001_0001) begin n_err++; $display("FAIL sw_ctrl got %b want 000010001", {a_wb, a_mem, a_ex}); end
      instr = 32'h10000008;
      tick();
      n_vec++; if ({a_wb, a_mem, a_ex} !== 9'b00_100_0010) begin n_err++; $display("FAIL beq_ctrl got %b want 001000010", {a_wb, a_mem, a_ex}); end
      n_vec++; if (a_sext !== 32'h8) begin n_err++; $display("FAIL beq_sext got %0h want 8", a_sext); end
      instr = 32'h20620005;
      tick();
      n_vec++; if ({a_wb, a_mem, a_ex} !== 9'b10_000_0001) begin n_err++; $display("FAIL addi_ctrl got %b want 100000001", {a_wb, a_mem, a_ex}); end
      instr = 32'hfc000000;
      tick();
      n_vec++; if ({a_valid, a_wb, a_mem, a_ex} !== 10'b1_00_000_0000) begin n_err++; $display("FAIL unk_ctrl got %b want 1000000000", {a_valid, a_wb, a_mem, a_ex}); end
      instr = 32'h20620005; valid = 1'b0;
      tick();
      n_vec++; if ({a_valid, a_wb} !== 3'b000) begin n_err++; $display("FAIL invalid_bubble got %b want 000", {a_valid, a_wb}); end
   endtask

   task automatic test_zero_reg();
      valid = 1'b1; instr = 32'h00001020;
      wb_reg_write = 1'b1; wb_loc = 5'd0; wb_data = 32'hdead;
      tick();
      wb_reg_write = 1'b0;
      n_vec++; if ({a_rd1, a_rd2} !== 64'h0) begin n_err++; $display("FAIL zero_bypass got %0h want 0", {a_rd1, a_rd2}); end
      tick();
      n_vec++; if ({a_rd1, b_rd1} !== 64'h0) begin n_err++; $display("FAIL zero_after got %0h want 0", {a_rd1, b_rd1}); end
   endtask

   task automatic test_async_reset();
      instr = 32'h00a41020; npc = 32'd5; valid = 1'b1;
      tick();
      n_vec++; if ({a_valid, a_rd1} !== {1'b1, 32'h20}) begin n_err++; $display("FAIL pre_arst got %0h want 100000020", {a_valid, a_rd1}); end
      #3;
      rst = 1'b0;
      #1;
      n_vec++; if ({a_valid, a_wb, a_ex, a_stall} !== 8'h0) begin n_err++; $display("FAIL arst_ctrl got %0h want 0", {a_valid, a_wb, a_ex, a_stall}); end
      n_vec++; if ({a_npc, a_rd1, a_rs} !== 69'h0) begin n_err++; $display("FAIL arst_data got %0h want 0", {a_npc, a_rd1, a_rs}); end
      n_vec++; if ({b_valid, b_rd1} !== 33'h0) begin n_err++; $display("FAIL arst_b got %0h want 0", {b_valid, b_rd1}); end
      #2;
      rst = 1'b1;
      tick();
      n_vec++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL post_arst_valid got %0h want 1", a_valid); end
      n_vec++; if ({a_rd1, a_rd2} !== 64'h0) begin n_err++; $display("FAIL post_arst_rf got %0h want 0", {a_rd1, a_rd2}); end
      n_vec++; if (a_npc !== 32'd5) begin n_err++; $display("FAIL post_arst_npc got %0h want 5", a_npc); end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_bypass();
      test_load_use();
      test_flush_hazard();
      test_hazard_edges();
      test_decode();
      test_zero_reg();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
